// File: rtl/mem_copy_engine.sv
// Block-move / block-fill engine driving memory port A.
// COPY takes RD -> CAP -> WR per word; FILL writes one word per cycle.
module mem_copy_engine #(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 16,
    parameter int LEN_W  = 16
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  length,
    input  logic [DATA_W-1:0] fill_data,
    output logic              busy,
    output logic              done,
    output logic [LEN_W-1:0]  words_done,
    output logic              write_memoryA,
    output logic [ADDR_W-1:0] memory_locationA,
    output logic [DATA_W-1:0] memory_inputA,
    input  logic [DATA_W-1:0] data_outA
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD      = 3'd1,
        CAP     = 3'd2,
        WR      = 3'd3,
        FILL_WR = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   src_reg, src_next;
    logic [ADDR_W-1:0]   dst_reg, dst_next;
    logic [LEN_W-1:0]    len_reg, len_next;
    logic [DATA_W-1:0]   fill_reg, fill_next;
    logic [DATA_W-1:0]   data_reg, data_next;
    // One bit wider than length so the final increment at 2^LEN_W-1 cannot wrap.
    logic [LEN_W:0]      i_reg, i_next;
    logic [LEN_W-1:0]    words_next;
    logic                busy_next, done_next, we_next;
    logic [ADDR_W-1:0]   loc_next;
    logic [DATA_W-1:0]   wdata_next;

    always_comb begin
        state_next = state_reg;
        src_next   = src_reg;
        dst_next   = dst_reg;
        len_next   = len_reg;
        fill_next  = fill_reg;
        data_next  = data_reg;
        i_next     = i_reg;
        words_next = words_done;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    src_next   = src_addr;
                    dst_next   = dst_addr;
                    len_next   = length;
                    fill_next  = fill_data;
                    i_next     = '0;
                    words_next = '0;
                    if (length == '0)
                        state_next = DONE;
                    else if (mode)
                        state_next = FILL_WR;
                    else
                        state_next = RD;
                end
            end
            RD:  state_next = CAP;
            CAP: begin
                data_next  = data_outA;
                state_next = WR;
            end
            WR, FILL_WR: begin
                i_next     = i_reg + (LEN_W+1)'(1);
                words_next = words_done + LEN_W'(1);
                if (i_next == {1'b0, len_reg})
                    state_next = DONE;
                else if (state_reg == WR)
                    state_next = RD;
                else
                    state_next = FILL_WR;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase

        // Outputs are computed for the upcoming state and registered below.
        busy_next  = (state_next != IDLE);
        done_next  = (state_next == DONE);
        we_next    = (state_next == WR) || (state_next == FILL_WR);
        loc_next   = '0;
        wdata_next = '0;
        case (state_next)
            RD:      loc_next = src_next + ADDR_W'(i_next);
            WR: begin
                loc_next   = dst_next + ADDR_W'(i_next);
                wdata_next = data_next;
            end
            FILL_WR: begin
                loc_next   = dst_next + ADDR_W'(i_next);
                wdata_next = fill_next;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg        <= IDLE;
            src_reg          <= '0;
            dst_reg          <= '0;
            len_reg          <= '0;
            fill_reg         <= '0;
            data_reg         <= '0;
            i_reg            <= '0;
            words_done       <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            write_memoryA    <= 1'b0;
            memory_locationA <= '0;
            memory_inputA    <= '0;
        end else begin
            state_reg        <= state_next;
            src_reg          <= src_next;
            dst_reg          <= dst_next;
            len_reg          <= len_next;
            fill_reg         <= fill_next;
            data_reg         <= data_next;
            i_reg            <= i_next;
            words_done       <= words_next;
            busy             <= busy_next;
            done             <= done_next;
            write_memoryA    <= we_next;
            memory_locationA <= loc_next;
            memory_inputA    <= wdata_next;
        end
    end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Directed bench for mem_copy_engine with a 1-cycle-latency memory model.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_mem_copy_engine;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic [23:0] src_addr = '0;
    logic [23:0] dst_addr = '0;
    logic [15:0] length = '0;
    logic [15:0] fill_data = '0;
    logic        busy, done;
    logic [15:0] words_done;
    logic        write_memoryA;
    logic [23:0] memory_locationA;
    logic [15:0] memory_inputA;
    logic [15:0] data_outA;

    int errors = 0;
    int checks = 0;

    mem_copy_engine dut (
        .CLK(CLK), .RESET(RESET), .start(start), .mode(mode),
        .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
        .fill_data(fill_data), .busy(busy), .done(done),
        .words_done(words_done), .write_memoryA(write_memoryA),
        .memory_locationA(memory_locationA), .memory_inputA(memory_inputA),
        .data_outA(data_outA)
    );

    always #5 CLK = ~CLK;

    // Sparse memory; the preload port lets the bench seed contents without a second writer.
    logic [15:0] mem [logic [23:0]];
    logic [23:0] wr_log [$];
    int          wr_cnt = 0;
    logic        pre_we = 1'b0;
    logic [23:0] pre_addr = '0;
    logic [15:0] pre_data = '0;
    logic [15:0] rd_data = '0;
    assign data_outA = rd_data;

    function automatic logic [15:0] peek(input logic [23:0] a);
        return mem.exists(a) ? mem[a] : 16'h0000;
    endfunction

    always @(posedge CLK) begin
        rd_data <= peek(memory_locationA);
        if (write_memoryA) begin
            mem[memory_locationA] = memory_inputA;
            wr_log.push_back(memory_locationA);
            wr_cnt <= wr_cnt + 1;
        end
        if (pre_we) mem[pre_addr] = pre_data;
    end

    task automatic preload(input logic [23:0] a, input logic [15:0] d);
        @(negedge CLK);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        @(negedge CLK);
        pre_we = 1'b0;
    endtask

    task automatic kick(input logic m, input logic [23:0] s, input logic [23:0] d,
                        input logic [15:0] l, input logic [15:0] f);
        @(negedge CLK);
        mode = m; src_addr = s; dst_addr = d; length = l; fill_data = f;
        start = 1'b1;
    endtask

    // Counts cycles after the start cycle until done is seen (400 = timed out).
    task automatic wait_done(output int cyc, output int we_n, output int we_first, output int we_last);
        cyc = 0; we_n = 0; we_first = -1; we_last = -1;
        while (cyc < 400) begin
            @(negedge CLK);
            start = 1'b0;
            cyc++;
            if (write_memoryA) begin
                we_n++;
                if (we_first < 0) we_first = cyc;
                we_last = cyc;
            end
            if (done) break;
        end
    endtask

    task automatic test_reset;
        RESET = 1'b1;
        repeat (3) @(negedge CLK);
        checks++;
        if ({busy, done, write_memoryA} !== 3'b000) begin
            errors++; $display("FAIL reset_ctrl: busy/done/we=%b required 000", {busy, done, write_memoryA});
        end
        checks++;
        if (memory_locationA !== 24'h0 || memory_inputA !== 16'h0 || words_done !== 16'h0) begin
            errors++; $display("FAIL reset_data: loc=%h in=%h wd=%0d required 0", memory_locationA, memory_inputA, words_done);
        end
        RESET = 1'b0;
        @(negedge CLK);
        $display("reset: busy=%b done=%b we=%b", busy, done, write_memoryA);
    endtask

    task automatic test_copy;
        int cyc, wn, wf, wl, base;
        for (int k = 0; k < 4; k++) preload(24'h000010 + 24'(k), 16'hA001 + 16'(k));
        base = wr_cnt;
        kick(1'b0, 24'h000010, 24'h000100, 16'd4, 16'h0);
        wait_done(cyc, wn, wf, wl);
        checks++;
        if (cyc != 13) begin errors++; $display("FAIL copy_latency: got %0d cycles required 13", cyc); end
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL copy_busy_done: busy=%b required 1", busy); end
        checks++;
        if (words_done !== 16'd4) begin errors++; $display("FAIL copy_words: got %0d required 4", words_done); end
        checks++;
        if (wr_cnt - base != 4) begin errors++; $display("FAIL copy_strobes: got %0d required 4", wr_cnt - base); end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (peek(24'h000100 + 24'(k)) !== 16'hA001 + 16'(k)) begin
                errors++; $display("FAIL copy_data[%0d]: got %h required %h", k, peek(24'h000100 + 24'(k)), 16'hA001 + 16'(k));
            end
        end
        @(negedge CLK);
        checks++;
        if ({busy, done} !== 2'b00) begin errors++; $display("FAIL copy_idle: busy/done=%b required 00", {busy, done}); end
        $display("copy: cycles=%0d words=%0d strobes=%0d", cyc, words_done, wr_cnt - base);
    endtask

    task automatic test_fill;
        int cyc, wn, wf, wl;
        preload(24'h000205, 16'h5555);
        kick(1'b1, 24'h0, 24'h000200, 16'd5, 16'hBEEF);
        wait_done(cyc, wn, wf, wl);
        checks++;
        if (cyc != 6) begin errors++; $display("FAIL fill_latency: got %0d cycles required 6", cyc); end
        checks++;
        if (wn != 5 || wf != 1 || wl != 5) begin
            errors++; $display("FAIL fill_strobe_run: count=%0d first=%0d last=%0d required 5/1/5", wn, wf, wl);
        end
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (peek(24'h000200 + 24'(k)) !== 16'hBEEF) begin
                errors++; $display("FAIL fill_data[%0d]: got %h required beef", k, peek(24'h000200 + 24'(k)));
            end
        end
        checks++;
        if (peek(24'h000205) !== 16'h5555) begin errors++; $display("FAIL fill_guard: got %h required 5555", peek(24'h000205)); end
        $display("fill: cycles=%0d strobes=%0d", cyc, wn);
    endtask

    task automatic test_len0_back_to_back;
        int cyc, wn, wf, wl;
        kick(1'b0, 24'h000010, 24'h000300, 16'd0, 16'h0);
        wait_done(cyc, wn, wf, wl);
        checks++;
        if (cyc != 1) begin errors++; $display("FAIL len0_latency: got %0d cycles required 1", cyc); end
        checks++;
        if (wn != 0 || words_done !== 16'd0) begin errors++; $display("FAIL len0_writes: strobes=%0d wd=%0d required 0/0", wn, words_done); end
        // start held through the DONE cycle must only take effect once back in IDLE
        start = 1'b1;
        @(negedge CLK);
        checks++;
        if ({busy, done} !== 2'b00) begin errors++; $display("FAIL start_on_done: busy/done=%b required 00", {busy, done}); end
        @(negedge CLK);
        start = 1'b0;
        checks++;
        if ({busy, done} !== 2'b11) begin errors++; $display("FAIL start_after_done: busy/done=%b required 11", {busy, done}); end
        @(negedge CLK);
        $display("len0: cycles=%0d strobes=%0d", cyc, wn);
    endtask

    task automatic test_wrap;
        int cyc, wn, wf, wl, base;
        logic [23:0] exp_a [4];
        exp_a[0] = 24'hFFFFFE; exp_a[1] = 24'hFFFFFF; exp_a[2] = 24'h000000; exp_a[3] = 24'h000001;
        base = wr_log.size();
        kick(1'b1, 24'h0, 24'hFFFFFE, 16'd4, 16'h1234);
        wait_done(cyc, wn, wf, wl);
        checks++;
        if (wr_log.size() - base != 4) begin errors++; $display("FAIL wrap_count: got %0d required 4", wr_log.size() - base); end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (wr_log.size() <= base + k || wr_log[base + k] !== exp_a[k] || peek(exp_a[k]) !== 16'h1234) begin
                errors++; $display("FAIL wrap_addr[%0d]: got %h required %h", k,
                    (wr_log.size() > base + k) ? wr_log[base + k] : 24'hxxxxxx, exp_a[k]);
            end
        end
        $display("wrap: cycles=%0d strobes=%0d", cyc, wn);
    endtask

    task automatic test_restart_ignored;
        int cyc, dones, done_at, base;
        for (int k = 0; k < 8; k++) preload(24'h000300 + 24'(k), 16'hC000 + 16'(k));
        base = wr_cnt;
        kick(1'b0, 24'h000300, 24'h000400, 16'd8, 16'h0);
        cyc = 0; dones = 0; done_at = -1;
        while (cyc < 40) begin
            @(negedge CLK);
            cyc++;
            start = (cyc == 5);
            if (cyc == 5) begin
                mode = 1'b1; src_addr = 24'h000500; dst_addr = 24'h000600; length = 16'd2; fill_data = 16'hDEAD;
            end
            if (done) begin dones++; done_at = cyc; end
        end
        start = 1'b0;
        checks++;
        if (dones != 1 || done_at != 25) begin errors++; $display("FAIL restart_done: pulses=%0d at=%0d required 1 at 25", dones, done_at); end
        checks++;
        if (wr_cnt - base != 8 || mem.exists(24'h000600)) begin
            errors++; $display("FAIL restart_writes: strobes=%0d stray=%0d required 8/0", wr_cnt - base, mem.exists(24'h000600));
        end
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (peek(24'h000400 + 24'(k)) !== 16'hC000 + 16'(k)) begin
                errors++; $display("FAIL restart_data[%0d]: got %h required %h", k, peek(24'h000400 + 24'(k)), 16'hC000 + 16'(k));
            end
        end
        $display("restart: done_pulses=%0d at=%0d strobes=%0d", dones, done_at, wr_cnt - base);
    endtask

    task automatic test_reset_mid;
        int cyc, wn, wf, wl, base, dones;
        for (int k = 0; k < 8; k++) preload(24'h000700 + 24'(k), 16'hD000 + 16'(k));
        base = wr_cnt;
        kick(1'b0, 24'h000700, 24'h000800, 16'd8, 16'h0);
        cyc = 0;
        while (cyc < 50 && wr_cnt - base < 2) begin
            @(negedge CLK);
            start = 1'b0;
            cyc++;
        end
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        checks++;
        if ({busy, done, write_memoryA} !== 3'b000 || memory_locationA !== 24'h0 || memory_inputA !== 16'h0 || words_done !== 16'h0) begin
            errors++; $display("FAIL midreset_outputs: busy=%b done=%b we=%b loc=%h in=%h wd=%0d required all 0",
                busy, done, write_memoryA, memory_locationA, memory_inputA, words_done);
        end
        dones = 0;
        repeat (30) begin
            @(negedge CLK);
            if (done) dones++;
        end
        checks++;
        if (wr_cnt - base != 2 || dones != 0 || mem.exists(24'h000802)) begin
            errors++; $display("FAIL midreset_abandon: strobes=%0d dones=%0d required 2/0", wr_cnt - base, dones);
        end
        kick(1'b0, 24'h000700, 24'h000900, 16'd2, 16'h0);
        wait_done(cyc, wn, wf, wl);
        checks++;
        if (cyc != 7 || wn != 2 || peek(24'h000900) !== 16'hD000 || peek(24'h000901) !== 16'hD001) begin
            errors++; $display("FAIL midreset_recover: cycles=%0d strobes=%0d d0=%h d1=%h required 7/2/d000/d001",
                cyc, wn, peek(24'h000900), peek(24'h000901));
        end
        $display("reset_mid: strobes_before=%0d recover_cycles=%0d", wr_cnt - base - wn, cyc);
    endtask

    initial begin
        test_reset();
        test_copy();
        test_fill();
        test_len0_back_to_back();
        test_wrap();
        test_restart_ignored();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_copy_engine.md
Name: mem_copy_engine

Overview:
- Initiator for memory port A of the Control block. Drives write_memoryA, memory_locationA and memory_inputA, and consumes data_outA.
- Moves a block of 16-bit words from a source address to a destination address (COPY mode), or writes a constant pattern over a region (FILL mode).
- Gives the datapath and test logic one start/busy/done handshake in place of hand-sequenced memory accesses.

Parameters:
- ADDR_W, 24, address width; matches memory_locationA.
- DATA_W, 16, data width; matches memory_inputA and data_outA.
- LEN_W, 16, width of the transfer word count.

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- RESET  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- mode  input  1  0 = COPY, 1 = FILL; latched on start.
- src_addr  input  ADDR_W  first source word address (COPY); latched on start.
- dst_addr  input  ADDR_W  first destination word address; latched on start.
- length  input  LEN_W  number of words to move; latched on start.
- fill_data  input  DATA_W  pattern for FILL; latched on start.
- busy  output  1  high from the cycle after an accepted start until DONE inclusive.
- done  output  1  one-cycle pulse when the transfer completes.
- words_done  output  LEN_W  count of words written so far in the current or last transfer.
- write_memoryA  output  1  memory write strobe.
- memory_locationA  output  ADDR_W  memory address.
- memory_inputA  output  DATA_W  memory write data.
- data_outA  input  DATA_W  memory read data; valid the cycle after the address is presented.

Behaviour:
- Reset (RESET=1 at an edge):
  - State goes to IDLE.
  - busy, done, write_memoryA = 0; memory_locationA, memory_inputA, words_done = 0.
  - Any in-flight transfer is abandoned with no further writes and no done pulse.
- Memory timing: read latency is exactly 1 cycle. With the address driven in cycle N and write_memoryA=0, data_outA is valid in cycle N+1. A write occurs at the edge ending a cycle with write_memoryA=1.
- Outputs are registered. write_memoryA is 1 only in WRITE state.
- IDLE:
  - Outputs are held at 0, except words_done, which keeps the last count.
  - On start=1, latch mode, src_addr, dst_addr, length and fill_data, and clear the index i and words_done.
  - Next state: DONE if length==0; FILL_WR if mode=1; otherwise RD.
- RD: memory_locationA = src+i, write_memoryA = 0. Go to CAP.
- CAP: data_outA is valid in this cycle; capture it into the data register at the end of the cycle. Go to WR.
- WR / FILL_WR:
  - memory_locationA = dst+i, memory_inputA = captured data (COPY) or fill_data (FILL), write_memoryA = 1.
  - At the end of the cycle, i and words_done increment.
  - If i+1 == length, go to DONE; otherwise go to RD (COPY) or stay in FILL_WR (FILL).
- DONE: done=1 and busy=1 for exactly one cycle, then IDLE.
- Throughput:
  - COPY: 3 cycles per word; a transfer takes 3*length+1 cycles from start acceptance to the done cycle inclusive.
  - FILL: 1 cycle per word, length+1 cycles.
  - length==0: 1 cycle (DONE only); no memory write.
- Address arithmetic: src+i and dst+i are modulo 2^ADDR_W. Address 0xFFFFFF+1 wraps to 0x000000 silently.
- The index i is LEN_W+1 bits wide internally. length = 2^LEN_W-1 must complete without overflow.
- start while busy (any non-IDLE state) is ignored: no re-latch, no effect on the current transfer.
- start on the same cycle as DONE is ignored. start is accepted the following cycle in IDLE.
- RESET and start asserted together: RESET wins.
- Overlapping regions: no hazard detection. The copy proceeds in ascending address order, word by word, so a later read returns data already overwritten by this transfer when dst < src+length and dst > src.
- Inputs other than start and data_outA are don't-care outside the start cycle.

Test Plan:
- Preload mem[0x000010..0x000013] = 0xA001..0xA004. COPY src=0x000010, dst=0x000100, length=4 -> mem[0x100..0x103] = 0xA001..0xA004; done pulses 13 cycles after start acceptance; words_done=4; exactly 4 write strobes.
- FILL dst=0x000200, length=5, fill_data=0xBEEF -> mem[0x200..0x204] = 0xBEEF; mem[0x205] unchanged; done after 6 cycles; write_memoryA high 5 consecutive cycles.
- COPY length=0 -> done one cycle after start; write_memoryA never asserts; words_done=0.
- FILL dst=0xFFFFFE, length=4, fill_data=0x1234 -> writes land at 0xFFFFFE, 0xFFFFFF, 0x000000, 0x000001.
- COPY length=8, start re-pulsed mid-transfer with different addresses -> second start ignored; the original 8 words are copied; a single done.
- COPY length=8, RESET asserted after 2 words written -> no further writes; busy=0 and all outputs 0 next cycle; no done; a new start afterwards completes normally.
